hazard_scoreboard_unit: RTL and testbench

Next-generation pipeline hazard block for the 5-stage core. It has three jobs:
- Generalised EX-stage operand forwarding for NUM_SRC source operands, MEM over WB priority.
- Load-use stall detection in decode.
- A scoreboard for the multi-cycle mul/div unit: it counts down the unit's latency, stalls dependent or conflicting instructions in decode, and signals completion for writeback.
Sits beside the pipeline registers between the decode and writeback control paths.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_scoreboard_unit_if.sv | 51 +++++
 rtl/fwd_select.sv | 32 +++
 rtl/hazard_scoreboard_unit.sv | 108 ++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard/scoreboard block: forwarding mux selects,
// the hardwired-zero register index and the width of the mul/div countdown.
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int unsigned REG_ZERO = 0;

  // Countdown width; MD_LAT must fit (2..15).
  localparam int unsigned MD_CNT_W = 4;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Bundle of the pipeline-side signals seen by the hazard scoreboard.
// The pipeline drives stage information and consumes the forwarding selects,
// stall controls and mul/div writeback status.
interface hazard_scoreboard_unit_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 32
);

  logic [NUM_SRC*REG_AW-1:0] src_D;
  logic [NUM_SRC-1:0]        src_used_D;
  logic [REG_AW-1:0]         dest_D;
  logic                      reg_write_D;
  logic                      md_op_D;
  logic [NUM_SRC*REG_AW-1:0] src_E;
  logic [REG_AW-1:0]         write_reg_E;
  logic                      reg_write_E;
  logic                      mem_to_reg_E;
  logic                      md_start_E;
  logic [REG_AW-1:0]         write_reg_M;
  logic                      reg_write_M;
  logic [REG_AW-1:0]         write_reg_W;
  logic                      reg_write_W;

  logic [2*NUM_SRC-1:0]      forward_E;
  logic                      stall_F;
  logic                      stall_D;
  logic                      flush_E;
  logic                      md_busy;
  logic                      md_done;
  logic [REG_AW-1:0]         md_dest;
  logic                      md_overlap_err;
  logic [CNT_W-1:0]          stall_cycles;

  modport master (
    output src_D, src_used_D, dest_D, reg_write_D, md_op_D,
    output src_E, write_reg_E, reg_write_E, mem_to_reg_E, md_start_E,
    output write_reg_M, reg_write_M, write_reg_W, reg_write_W,
    input  forward_E, stall_F, stall_D, flush_E,
    input  md_busy, md_done, md_dest, md_overlap_err, stall_cycles
  );

  modport slave (
    input  src_D, src_used_D, dest_D, reg_write_D, md_op_D,
    input  src_E, write_reg_E, reg_write_E, mem_to_reg_E, md_start_E,
    input  write_reg_M, reg_write_M, write_reg_W, reg_write_W,
    output forward_E, stall_F, stall_D, flush_E,
    output md_busy, md_done, md_dest, md_overlap_err, stall_cycles
  );

endinterface

// File: rtl/fwd_select.sv
// Forwarding select for a single EX-stage source operand.
// The younger MEM result takes priority over WB; r0 is never forwarded.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] write_reg_M,
  input  logic              reg_write_M,
  input  logic [REG_AW-1:0] write_reg_W,
  input  logic              reg_write_W,
  output logic [1:0]        fwd_sel
);

  logic m_hit;
  logic w_hit;

  assign m_hit = reg_write_M && (write_reg_M != REG_AW'(REG_ZERO)) && (write_reg_M == src);
  assign w_hit = reg_write_W && (write_reg_W != REG_AW'(REG_ZERO)) && (write_reg_W == src);

  // Pick MEM first, then WB, otherwise read the register file.
  always_comb begin
    fwd_sel = FWD_REG;
    if (m_hit) begin
      fwd_sel = FWD_MEM;
    end else if (w_hit) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard block: EX operand forwarding, load-use stall detection and
// a single-entry scoreboard for the multi-cycle mul/div unit with a
// saturating stall-cycle counter.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MD_LAT  = 4,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hazard_scoreboard_unit_if.slave hz
);

  localparam logic [MD_CNT_W-1:0] MD_LAT_CNT = MD_CNT_W'(MD_LAT);
  localparam logic [REG_AW-1:0]   ZERO_REG   = REG_AW'(REG_ZERO);

  logic [MD_CNT_W-1:0] cnt_q;
  logic [REG_AW-1:0]   md_dest_q;
  logic                md_done_q;
  logic                overlap_err_q;
  logic [CNT_W-1:0]    stall_cnt_q;

  logic md_busy;
  logic lu_match;
  logic raw_match;
  logic lu;
  logic mdh;
  logic stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_select #(.REG_AW(REG_AW)) u_fwd (
      .src         (hz.src_E[i*REG_AW +: REG_AW]),
      .write_reg_M (hz.write_reg_M),
      .reg_write_M (hz.reg_write_M),
      .write_reg_W (hz.write_reg_W),
      .reg_write_W (hz.reg_write_W),
      .fwd_sel     (hz.forward_E[2*i +: 2])
    );
  end

  assign md_busy = (cnt_q != '0);

  // Scan decode operands for a match against the EX load and the pending mul/div.
  always_comb begin
    lu_match  = 1'b0;
    raw_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (hz.src_used_D[i] && (hz.src_D[i*REG_AW +: REG_AW] == hz.write_reg_E)) begin
        lu_match = 1'b1;
      end
      if (hz.src_used_D[i] && (hz.src_D[i*REG_AW +: REG_AW] == md_dest_q)) begin
        raw_match = 1'b1;
      end
    end
  end

  // Combine load-use and mul/div conditions (RAW, WAW, structural) into one stall.
  always_comb begin
    lu    = hz.reg_write_E && hz.mem_to_reg_E && (hz.write_reg_E != ZERO_REG) && lu_match;
    mdh   = md_busy && (((md_dest_q != ZERO_REG) && raw_match) ||
                        (hz.reg_write_D && (hz.dest_D == md_dest_q) && (md_dest_q != ZERO_REG)) ||
                        hz.md_op_D);
    stall = lu || mdh;
  end

  // Mul/div countdown: accept a start only when idle, flag starts that arrive while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      md_dest_q     <= '0;
      md_done_q     <= 1'b0;
      overlap_err_q <= 1'b0;
    end else begin
      md_done_q <= (cnt_q == MD_CNT_W'(1));
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - MD_CNT_W'(1);
        if (hz.md_start_E) begin
          overlap_err_q <= 1'b1;
        end
      end else if (hz.md_start_E) begin
        cnt_q     <= MD_LAT_CNT;
        md_dest_q <= hz.write_reg_E;
      end
    end
  end

  // Count stalled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.stall_F        = stall;
  assign hz.stall_D        = stall;
  assign hz.flush_E        = stall;
  assign hz.md_busy        = md_busy;
  assign hz.md_done        = md_done_q;
  assign hz.md_dest        = md_dest_q;
  assign hz.md_overlap_err = overlap_err_q;
  assign hz.stall_cycles   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// timestamp-based model of the scoreboard and the hazard rules.
module tb_hazard_scoreboard_unit;

  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;
  localparam int MD_LAT  = 4;
  localparam int CNT_W   = 4;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  hazard_scoreboard_unit_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) hif ();

  hazard_scoreboard_unit #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MD_LAT(MD_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_idle();
    hif.src_D        = '0;
    hif.src_used_D   = '0;
    hif.dest_D       = '0;
    hif.reg_write_D  = 1'b0;
    hif.md_op_D      = 1'b0;
    hif.src_E        = '0;
    hif.write_reg_E  = '0;
    hif.reg_write_E  = 1'b0;
    hif.mem_to_reg_E = 1'b0;
    hif.md_start_E   = 1'b0;
    hif.write_reg_M  = '0;
    hif.reg_write_M  = 1'b0;
    hif.write_reg_W  = '0;
    hif.reg_write_W  = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus();
    hif.src_D        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    hif.src_used_D   = 2'($urandom_range(0, 3));
    hif.dest_D       = 5'($urandom_range(0, 7));
    hif.reg_write_D  = 1'($urandom_range(0, 1));
    hif.md_op_D      = ($urandom_range(0, 3) == 0);
    hif.src_E        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    hif.write_reg_E  = 5'($urandom_range(0, 7));
    hif.reg_write_E  = 1'($urandom_range(0, 1));
    hif.mem_to_reg_E = 1'($urandom_range(0, 1));
    hif.md_start_E   = ($urandom_range(0, 3) == 0);
    hif.write_reg_M  = 5'($urandom_range(0, 7));
    hif.reg_write_M  = 1'($urandom_range(0, 1));
    hif.write_reg_W  = 5'($urandom_range(0, 7));
    hif.reg_write_W  = 1'($urandom_range(0, 1));
    rst_n            = ($urandom_range(0, 299) != 0);
  endtask

  // Reference model: the scoreboard is an accepted-start timestamp, busy while
  // fewer than MD_LAT edges have passed, done exactly MD_LAT edges after it.
  int          m_t;
  bit          m_have;
  int          m_start;
  logic [4:0]  m_dest;
  bit          m_err;
  int          m_stalls;

  // Compare every DUT output against the model shortly before each rising edge.
  always @(negedge clk) begin : compare
    logic [3:0] exp_fwd;
    bit         exp_busy;
    bit         exp_done;
    bit         lu;
    bit         raw;
    bit         mdh;
    bit         exp_stall;
    logic [4:0] s;
    #3;
    if (!rst_n) begin
      m_t = 0; m_have = 0; m_start = 0; m_dest = '0; m_err = 0; m_stalls = 0;
    end
    exp_busy = m_have && ((m_t - m_start) < MD_LAT);
    exp_done = m_have && ((m_t - m_start) == MD_LAT);
    lu  = 0;
    raw = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s = hif.src_E[i*REG_AW +: REG_AW];
      if (hif.reg_write_M && hif.write_reg_M != 0 && hif.write_reg_M == s)      exp_fwd[2*i +: 2] = 2'b10;
      else if (hif.reg_write_W && hif.write_reg_W != 0 && hif.write_reg_W == s) exp_fwd[2*i +: 2] = 2'b01;
      else                                                                    exp_fwd[2*i +: 2] = 2'b00;
      s = hif.src_D[i*REG_AW +: REG_AW];
      if (hif.src_used_D[i] && s == hif.write_reg_E) lu = 1;
      if (hif.src_used_D[i] && s == m_dest && m_dest != 0) raw = 1;
    end
    lu  = lu && hif.reg_write_E && hif.mem_to_reg_E && (hif.write_reg_E != 0);
    mdh = exp_busy && (raw || (hif.reg_write_D && hif.dest_D == m_dest && m_dest != 0) || hif.md_op_D);
    exp_stall = lu || mdh;

    check_output("forward_E", 32'(hif.forward_E), 32'(exp_fwd));
    check_output("stall_F", 32'(hif.stall_F), 32'(exp_stall));
    check_output("stall_D", 32'(hif.stall_D), 32'(exp_stall));
    check_output("flush_E", 32'(hif.flush_E), 32'(exp_stall));
    check_output("md_busy", 32'(hif.md_busy), 32'(exp_busy));
    check_output("md_done", 32'(hif.md_done), 32'(exp_done));
    check_output("md_dest", 32'(hif.md_dest), 32'(m_dest));
    check_output("md_overlap_err", 32'(hif.md_overlap_err), 32'(m_err));
    check_output("stall_cycles", 32'(hif.stall_cycles), 32'(m_stalls));

    if (rst_n) begin
      m_t++;
      if (exp_stall && m_stalls < SAT) m_stalls++;
      if (hif.md_start_E) begin
        if (exp_busy) begin
          m_err = 1;
        end else begin
          m_have  = 1;
          m_start = m_t;
          m_dest  = hif.write_reg_E;
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    apply_idle();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    #3;
    check_output("reset md_busy", 32'(hif.md_busy), 32'd0);
    check_output("reset md_done", 32'(hif.md_done), 32'd0);
    check_output("reset md_dest", 32'(hif.md_dest), 32'd0);
    check_output("reset md_overlap_err", 32'(hif.md_overlap_err), 32'd0);
    check_output("reset stall_cycles", 32'(hif.stall_cycles), 32'd0);

    // Forwarding priority and r0 exclusion.
    next_cycle(); apply_idle();
    hif.src_E = {5'd3, 5'd3};
    hif.write_reg_M = 5'd3; hif.reg_write_M = 1'b1;
    hif.write_reg_W = 5'd3; hif.reg_write_W = 1'b1;
    #3 check_output("fwd mem over wb", 32'(hif.forward_E), 32'b1010);
    next_cycle(); hif.reg_write_M = 1'b0;
    #3 check_output("fwd wb only", 32'(hif.forward_E), 32'b0101);
    next_cycle(); hif.reg_write_M = 1'b1; hif.write_reg_M = '0; hif.write_reg_W = '0;
    #3 check_output("fwd r0", 32'(hif.forward_E), 32'b0000);

    // Load-use stall on operand 1, then the same with the operand unused.
    next_cycle(); apply_idle();
    hif.reg_write_E = 1'b1; hif.mem_to_reg_E = 1'b1; hif.write_reg_E = 5'd5;
    hif.src_D = {5'd5, 5'd0}; hif.src_used_D = 2'b10;
    #3 check_output("lu stall_F", 32'(hif.stall_F), 32'd1);
    check_output("lu stall_D", 32'(hif.stall_D), 32'd1);
    check_output("lu flush_E", 32'(hif.flush_E), 32'd1);
    next_cycle(); apply_idle();
    #3 check_output("lu stall count", 32'(hif.stall_cycles), 32'd1);
    next_cycle();
    hif.reg_write_E = 1'b1; hif.mem_to_reg_E = 1'b1; hif.write_reg_E = 5'd5;
    hif.src_D = {5'd5, 5'd0}; hif.src_used_D = 2'b00;
    #3 check_output("lu unused", 32'(hif.stall_D), 32'd0);

    // Mul/div to r7, decode reads r7 throughout.
    next_cycle(); apply_idle(); hif.md_start_E = 1'b1; hif.write_reg_E = 5'd7;
    #3 check_output("md idle before start", 32'(hif.md_busy), 32'd0);
    for (int k = 0; k < MD_LAT; k++) begin
      next_cycle(); apply_idle(); hif.src_D = {5'd0, 5'd7}; hif.src_used_D = 2'b01;
      #3 check_output("md busy", 32'(hif.md_busy), 32'd1);
      check_output("md raw stall", 32'(hif.stall_D), 32'd1);
      check_output("md not done", 32'(hif.md_done), 32'd0);
    end
    next_cycle();
    #3 check_output("md busy drop", 32'(hif.md_busy), 32'd0);
    check_output("md done pulse", 32'(hif.md_done), 32'd1);
    check_output("md raw clear", 32'(hif.stall_D), 32'd0);
    check_output("md dest", 32'(hif.md_dest), 32'd7);

    // Unrelated read, structural and WAW stalls while busy.
    next_cycle(); apply_idle(); hif.md_start_E = 1'b1; hif.write_reg_E = 5'd7;
    next_cycle(); apply_idle(); hif.src_D = {5'd0, 5'd8}; hif.src_used_D = 2'b01;
    #3 check_output("md r8 no stall", 32'(hif.stall_D), 32'd0);
    next_cycle(); apply_idle(); hif.md_op_D = 1'b1;
    #3 check_output("md structural", 32'(hif.stall_D), 32'd1);
    next_cycle(); apply_idle(); hif.reg_write_D = 1'b1; hif.dest_D = 5'd7;
    #3 check_output("md waw", 32'(hif.stall_D), 32'd1);
    next_cycle(); hif.md_op_D = 1'b1;
    #3 check_output("md last busy stall", 32'(hif.stall_D), 32'd1);
    next_cycle();
    #3 check_output("md stall clears", 32'(hif.stall_D), 32'd0);

    // Overlapping start at cnt=2 is ignored and latches the error.
    next_cycle(); apply_idle(); hif.md_start_E = 1'b1; hif.write_reg_E = 5'd7;
    next_cycle(); apply_idle();
    next_cycle(); apply_idle();
    next_cycle(); apply_idle(); hif.md_start_E = 1'b1; hif.write_reg_E = 5'd9;
    #3 check_output("overlap before", 32'(hif.md_overlap_err), 32'd0);
    next_cycle(); apply_idle();
    #3 check_output("overlap err", 32'(hif.md_overlap_err), 32'd1);
    check_output("overlap dest kept", 32'(hif.md_dest), 32'd7);
    next_cycle();
    #3 check_output("overlap done on time", 32'(hif.md_done), 32'd1);
    next_cycle();
    #3 check_output("overlap sticky", 32'(hif.md_overlap_err), 32'd1);

    // Asynchronous reset in the middle of a countdown.
    next_cycle(); apply_idle(); hif.md_start_E = 1'b1; hif.write_reg_E = 5'd4;
    next_cycle(); apply_idle();
    next_cycle(); apply_idle();
    next_cycle(); apply_idle();
    #1 rst_n = 1'b0;
    #2 check_output("async rst busy", 32'(hif.md_busy), 32'd0);
    check_output("async rst done", 32'(hif.md_done), 32'd0);
    check_output("async rst err", 32'(hif.md_overlap_err), 32'd0);
    next_cycle(); rst_n = 1'b1;

    // Hold a load-use stall long enough to saturate the counter.
    next_cycle();
    hif.reg_write_E = 1'b1; hif.mem_to_reg_E = 1'b1; hif.write_reg_E = 5'd5;
    hif.src_D = {5'd0, 5'd5}; hif.src_used_D = 2'b01;
    repeat (20) next_cycle();
    #3 check_output("stall saturate", 32'(hif.stall_cycles), 32'(SAT));

    // Randomized traffic, checked by the compare process.
    for (int n = 0; n < 2000; n++) begin
      next_cycle();
      apply_stimulus();
    end
    next_cycle(); apply_idle(); rst_n = 1'b1;
    next_cycle();
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
